// File: rtl/rx_fifo_burst_ctrl.sv
// Drain scheduler for the video RX FIFO: requests a DDR write slot once a full
// burst is buffered, then streams exactly one burst through a 2-entry skid buffer.
module rx_fifo_burst_ctrl #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    LEVEL_WIDTH  = 11,
  parameter int                    BURST_LEN    = 64,
  parameter int                    ADDR_WIDTH   = 28,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    FRAME_BURSTS = 32400
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
  input  logic                   fifo_rd_empty,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  output logic                   burst_req,
  output logic [ADDR_WIDTH-1:0]  burst_addr,
  input  logic                   burst_gnt,
  output logic [DATA_WIDTH-1:0]  wdata,
  output logic                   wvalid,
  input  logic                   wready,
  output logic                   wlast,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int CNT_W  = $clog2(BURST_LEN + 1);
  localparam int BCNT_W = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;

  localparam logic [ADDR_WIDTH-1:0]  STEP       = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);
  localparam logic [CNT_W-1:0]       LEN        = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]       LAST_WORD  = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1);
  localparam logic [BCNT_W-1:0]      LAST_BURST = BCNT_W'(FRAME_BURSTS - 1);
  localparam logic [BCNT_W-1:0]      BCNT_ONE   = BCNT_W'(1);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_TH   = LEVEL_WIDTH'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BCNT_W-1:0]       burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0]        rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;
  logic                    pend_q, pend_d;
  logic                    frame_done_q, frame_done_d;
  logic                    rd_pend_q;
  logic [1:0]              occ_q, occ_d;
  logic                    head_q, head_d;
  logic [DATA_WIDTH-1:0]   buf_q [2];

  logic                    occ_nz;
  logic                    hs;
  logic                    push;
  logic                    pop;
  logic                    wr_idx;
  logic                    restart;

  // Skid buffer: the word returning from the FIFO is shown directly when the
  // buffer is empty, so the stream starts one cycle after the first read.
  always_comb begin
    occ_nz     = (occ_q != 2'd0);
    wvalid     = occ_nz || rd_pend_q;
    wdata      = occ_nz ? buf_q[head_q] : fifo_rd_data;
    wlast      = wvalid && (out_cnt_q == LAST_WORD);
    hs         = wvalid && wready;
    fifo_rd_en = (state_q == XFER) && (rd_cnt_q < LEN) && !fifo_rd_empty &&
                 ((occ_q + {1'b0, rd_pend_q}) < 2'd2);
    push       = rd_pend_q && (occ_nz || !wready);
    pop        = hs && occ_nz;
    wr_idx     = head_q ^ occ_q[0];
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    head_d     = head_q ^ pop;
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    addr_d       = addr_q;
    burst_cnt_d  = burst_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    out_cnt_d    = out_cnt_q;
    pend_d       = pend_q;
    frame_done_d = 1'b0;
    restart      = 1'b0;

    unique case (state_q)
      IDLE: begin
        restart = frame_start;
        if (fifo_rd_water_level >= LEVEL_TH) state_d = REQ;
      end
      REQ: begin
        restart = frame_start;
        if (burst_gnt) begin
          state_d   = XFER;
          rd_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      XFER: begin
        if (fifo_rd_en) rd_cnt_d = rd_cnt_q + CNT_ONE;
        if (hs) out_cnt_d = out_cnt_q + CNT_ONE;
        if (frame_start) pend_d = 1'b1;
        if (hs && wlast) begin
          state_d = IDLE;
          pend_d  = 1'b0;
          // A pending restart wins over both the frame wrap and its frame_done.
          if (pend_q || frame_start) begin
            restart = 1'b1;
          end else if (burst_cnt_q == LAST_BURST) begin
            restart      = 1'b1;
            frame_done_d = 1'b1;
          end else begin
            addr_d      = addr_q + STEP;
            burst_cnt_d = burst_cnt_q + BCNT_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (restart) begin
      addr_d      = BASE_ADDR;
      burst_cnt_d = '0;
    end
  end

  assign burst_req  = (state_q == REQ);
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  // A frame restart outside a transfer is visible on the address immediately.
  assign burst_addr = (frame_start && (state_q != XFER)) ? BASE_ADDR : addr_q;

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours regardless of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= BASE_ADDR;
      burst_cnt_q  <= '0;
      rd_cnt_q     <= '0;
      out_cnt_q    <= '0;
      pend_q       <= 1'b0;
      frame_done_q <= 1'b0;
      rd_pend_q    <= 1'b0;
      occ_q        <= 2'd0;
      head_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      burst_cnt_q  <= burst_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      out_cnt_q    <= out_cnt_d;
      pend_q       <= pend_d;
      frame_done_q <= frame_done_d;
      rd_pend_q    <= fifo_rd_en;
      occ_q        <= occ_d;
      head_q       <= head_d;
    end
  end

  // NOTE: buffer storage is not reset; occ_q qualifies every entry, so stale
  // contents are never observed.
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_idx] <= fifo_rd_data;
  end

endmodule

// File: tb/tb_rx_fifo_burst_ctrl.sv
// Scoreboard bench for rx_fifo_burst_ctrl: a FIFO model feeds words whose
// expected order and wlast position are queued on push and checked on handshake.
module tb_rx_fifo_burst_ctrl;

  localparam int          DW   = 32;
  localparam int          LW   = 11;
  localparam int          BL   = 64;
  localparam int          AW   = 28;
  localparam logic [AW-1:0] BASE = 28'h0100000;
  localparam int          FB   = 3;
  localparam logic [AW-1:0] STEP = 28'd256;

  logic          clk;
  logic          rst_n;
  logic          frame_start;
  logic [LW-1:0] fifo_rd_water_level;
  logic          fifo_rd_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          burst_req;
  logic [AW-1:0] burst_addr;
  logic          burst_gnt;
  logic [DW-1:0] wdata;
  logic          wvalid;
  logic          wready;
  logic          wlast;
  logic          frame_done;
  logic          busy;

  rx_fifo_burst_ctrl #(
    .DATA_WIDTH(DW), .LEVEL_WIDTH(LW), .BURST_LEN(BL), .ADDR_WIDTH(AW),
    .BASE_ADDR(BASE), .FRAME_BURSTS(FB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .fifo_rd_water_level(fifo_rd_water_level), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .burst_req(burst_req), .burst_addr(burst_addr), .burst_gnt(burst_gnt),
    .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .frame_done(frame_done), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: read data appears the cycle after fifo_rd_en.
  logic [DW-1:0] fmem [1024];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          force_empty = 1'b0;

  assign fifo_rd_water_level = LW'(wr_ptr - rd_ptr);
  assign fifo_rd_empty       = (wr_ptr == rd_ptr) || force_empty;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en) begin
      fifo_rd_data <= fmem[rd_ptr % 1024];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Scoreboard / stream monitor
  logic [DW-1:0] exp_q [$];
  int            bcount    = 0;
  int            acc_total = 0;
  int            max_out   = 0;
  int            fd_cnt    = 0;
  logic          prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic [DW-1:0] exp_w;

  always @(negedge clk) begin
    if (!rst_n) begin
      bcount    = 0;
      exp_q.delete();
      acc_total = rd_ptr;
      prev_v    = 1'b0;
    end else begin
      if (rd_ptr - acc_total > max_out) max_out = rd_ptr - acc_total;
      if (prev_v && !prev_r) begin
        check("hold_wvalid", wvalid, 1);
        check("hold_wdata", wdata, prev_d);
        check("hold_wlast", wlast, prev_l);
      end
      if (wvalid && wready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", exp_q.size(), 1);
        end else begin
          exp_w = exp_q.pop_front();
          check("wdata", wdata, exp_w);
          check("wlast", wlast, bcount == BL - 1);
        end
        bcount = (bcount == BL - 1) ? 0 : bcount + 1;
        acc_total++;
      end
      if (frame_done) fd_cnt++;
      prev_v = wvalid;
      prev_r = wready;
      prev_d = wdata;
      prev_l = wlast;
    end
  end

  // wready: mode 0 always high; mode 1 toggles with a 10-cycle low window.
  int rdy_mode = 0;
  initial begin : rdy_drv
    int mcyc;
    int last_mode;
    wready    = 1'b1;
    mcyc      = 0;
    last_mode = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode != last_mode) mcyc = 0;
      last_mode = rdy_mode;
      mcyc++;
      if (rdy_mode == 0) wready = 1'b1;
      else wready = (mcyc % 2 == 0) && !(mcyc >= 40 && mcyc < 50);
    end
  end

  task automatic push_words(input int n);
    logic [DW-1:0] v;
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      v = $urandom;
      fmem[wr_ptr % 1024] = v;
      exp_q.push_back(v);
      wr_ptr++;
    end
  endtask

  task automatic wait_req(input logic [AW-1:0] exp_addr);
    int cyc = 0;
    while (!burst_req && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("req_seen", burst_req, 1);
    check("req_addr", burst_addr, exp_addr);
  endtask

  task automatic grant_after_3;
    repeat (3) @(posedge clk);
    #1 burst_gnt = 1'b1;
    @(posedge clk);
    #1 burst_gnt = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_burst(input logic [AW-1:0] exp_addr, input bit fs_req,
                           input int fs_at, input int stall_at, input bit timing);
    int cyc;
    wait_req(exp_addr);
    if (fs_req) begin
      @(posedge clk);
      #1 frame_start = 1'b1;
      @(negedge clk);
      check("fs_req_addr", burst_addr, BASE);
      check("fs_req_held", burst_req, 1);
      @(posedge clk);
      #1 frame_start = 1'b0;
      @(negedge clk);
      check("fs_req_addr_q", burst_addr, BASE);
      check("fs_req_held_q", burst_req, 1);
    end
    grant_after_3();
    if (timing) begin
      check("g1_busy", busy, 1);
      check("g1_rd_en", fifo_rd_en, 1);
      check("g1_wvalid", wvalid, 0);
      check("g1_req", burst_req, 0);
    end
    cyc = 1;
    while (busy && cyc < 3000) begin
      @(posedge clk);
      #1;
      force_empty = (stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + 5);
      frame_start = (cyc == fs_at);
      @(negedge clk);
      cyc++;
      if (force_empty) check("stall_rd_en", fifo_rd_en, 0);
      if (timing && cyc == 2) check("first_wvalid", wvalid, 1);
    end
    force_empty = 1'b0;
    frame_start = 1'b0;
    check("burst_done", busy, 0);
    if (timing) check("busy_fall_cycle", cyc, 2 + BL);
  endtask

  initial begin : main
    int cyc;
    rst_n       = 1'b0;
    frame_start = 1'b0;
    burst_gnt   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", burst_req, 0);
    check("rst_addr", burst_addr, BASE);
    check("rst_wvalid", wvalid, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Level 63 must not request; 64 requests one cycle later.
    push_words(BL - 1);
    repeat (4) @(negedge clk);
    check("lvl63_no_req", burst_req, 0);
    push_words(1);
    @(negedge clk);
    check("lvl64_req_n", burst_req, 0);
    @(negedge clk);
    check("lvl64_req_n1", burst_req, 1);
    run_burst(BASE, 0, -1, -1, 1);

    push_words(BL);
    rdy_mode = 1;
    run_burst(BASE + STEP, 0, -1, -1, 0);
    rdy_mode = 0;

    push_words(BL);
    run_burst(BASE + 2 * STEP, 0, -1, 20, 0);
    check("frame_done_pulse", frame_done, 1);
    @(negedge clk);
    check("frame_done_single", frame_done, 0);

    push_words(BL);
    run_burst(BASE, 0, -1, -1, 0);
    push_words(BL);
    run_burst(BASE + STEP, 0, -1, -1, 0);

    // frame_start while requesting at +512, then mid-transfer at +256.
    push_words(BL);
    run_burst(BASE + 2 * STEP, 1, -1, -1, 0);
    push_words(BL);
    run_burst(BASE + STEP, 0, 20, -1, 0);
    push_words(BL);
    run_burst(BASE, 0, -1, -1, 0);

    // Reset at word 20 of a burst at +256.
    push_words(BL);
    wait_req(BASE + STEP);
    grant_after_3();
    cyc = 0;
    while (bcount != 20 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_reached_w20", bcount, 20);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", burst_req, 0);
    check("arst_addr", burst_addr, BASE);
    check("arst_wvalid", wvalid, 0);
    check("arst_wlast", wlast, 0);
    check("arst_rd_en", fifo_rd_en, 0);
    check("arst_busy", busy, 0);
    check("arst_frame_done", frame_done, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    push_words(BL - 1);
    repeat (5) @(negedge clk);
    check("post_rst_no_req", burst_req, 0);
    push_words(1);
    run_burst(BASE, 0, -1, -1, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("max_outstanding_le2", max_out <= 2, 1);
    check("frame_done_count", fd_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
